// File: rtl/lms_pkg.sv
// Shared types and arithmetic helpers for the adaptive LMS filter stage.
// Saturation works on a wide signed carrier so every caller can narrow from one place.
package lms_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILTER = 2'd1,
      ERROR  = 2'd2,
      UPDATE = 2'd3
   } lms_state_e;

   localparam int LMS_DW       = 24;
   localparam int LMS_TAPS     = 8;
   localparam int LMS_MU_SHIFT = 8;
   localparam int SAT_W        = 64;

   // Accumulator holds TAPS full-precision products without overflow.
   function automatic int acc_width(input int dw, input int taps);
      return 2 * dw + $clog2(taps);
   endfunction

   function automatic logic signed [SAT_W-1:0] sat_hi(input int dw);
      return (64'sd1 <<< (dw - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [SAT_W-1:0] sat_lo(input int dw);
      return -(64'sd1 <<< (dw - 1));
   endfunction

   function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] v,
                                                      input int dw);
      if (v > sat_hi(dw)) begin
         return sat_hi(dw);
      end else if (v < sat_lo(dw)) begin
         return sat_lo(dw);
      end
      return v;
   endfunction

endpackage

// File: rtl/lms_filter_if.sv
// Sample/result bundle between the sine generator side and the LMS filter stage.
interface lms_filter_if import lms_pkg::*; #(
   parameter int DW = LMS_DW
);
   logic signed [DW-1:0] x_in;
   logic signed [DW-1:0] d_in;
   logic                 in_valid;
   logic                 adapt_en;
   logic signed [DW-1:0] y_out;
   logic signed [DW-1:0] e_out;
   logic                 out_valid;
   logic                 busy;
   logic                 overrun;

   modport master (
      output x_in, d_in, in_valid, adapt_en,
      input  y_out, e_out, out_valid, busy, overrun
   );

   modport slave (
      input  x_in, d_in, in_valid, adapt_en,
      output y_out, e_out, out_valid, busy, overrun
   );
endinterface

// File: rtl/lms_mac.sv
// Single shared signed multiplier: w*x accumulation while filtering,
// e*x scaled by mu and added to the coefficient while updating.
module lms_mac import lms_pkg::*; #(
   parameter int DW       = LMS_DW,
   parameter int AW       = acc_width(LMS_DW, LMS_TAPS),
   parameter int MU_SHIFT = LMS_MU_SHIFT
) (
   input  logic                 filt_sel,
   input  logic signed [DW-1:0] w_k,
   input  logic signed [DW-1:0] x_k,
   input  logic signed [DW-1:0] e_val,
   input  logic signed [AW-1:0] acc_in,
   output logic signed [AW-1:0] acc_out,
   output logic signed [DW-1:0] w_new
);
   localparam int PW = 2 * DW;

   logic signed [DW-1:0]    op_a;
   logic signed [PW-1:0]    prod;
   logic signed [PW-1:0]    step;
   logic signed [SAT_W-1:0] w_sum;

   always_comb begin
      op_a    = filt_sel ? w_k : e_val;
      prod    = $signed({{DW{op_a[DW-1]}}, op_a}) * $signed({{DW{x_k[DW-1]}}, x_k});
      acc_out = acc_in + $signed({{(AW-PW){prod[PW-1]}}, prod});
      // Arithmetic shift floors toward -inf; mu folds into the Q1.23 renormalisation.
      step    = prod >>> (DW - 1 + MU_SHIFT);
      w_sum   = $signed({{(SAT_W-DW){w_k[DW-1]}}, w_k})
              + $signed({{(SAT_W-PW){step[PW-1]}}, step});
      w_new   = DW'(sat_dw(w_sum, DW));
   end
endmodule

// File: rtl/lms_filter.sv
// Adaptive LMS FIR stage: one time-shared MAC computes y over TAPS cycles,
// then (optionally) adapts the coefficients over another TAPS cycles.
module lms_filter import lms_pkg::*; #(
   parameter int DW       = LMS_DW,
   parameter int TAPS     = LMS_TAPS,
   parameter int MU_SHIFT = LMS_MU_SHIFT
) (
   input logic         clk,
   input logic         reset,
   lms_filter_if.slave bus
);
   localparam int AW = acc_width(DW, TAPS);
   localparam int KW = $clog2(TAPS);
   localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

   lms_state_e state_q, state_d;

   logic signed [DW-1:0] x_q [TAPS];
   logic signed [DW-1:0] x_d [TAPS];
   logic signed [DW-1:0] w_q [TAPS];
   logic signed [DW-1:0] w_d [TAPS];

   logic signed [DW-1:0] d_q, d_d;
   logic signed [DW-1:0] y_q, y_d;
   logic signed [DW-1:0] e_q, e_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [KW-1:0]        k_q, k_d;
   logic                 adapt_q, adapt_d;
   logic                 out_valid_q, out_valid_d;
   logic                 overrun_q, overrun_d;

   logic                 filt_sel;
   logic signed [DW-1:0] w_k, x_k, w_new, y_calc;
   logic signed [AW-1:0] acc_next;
   logic signed [DW:0]   e_wide;

   assign filt_sel = (state_q == FILTER);
   assign w_k      = w_q[k_q];
   assign x_k      = x_q[k_q];

   lms_mac #(
      .DW       (DW),
      .AW       (AW),
      .MU_SHIFT (MU_SHIFT)
   ) u_mac (
      .filt_sel (filt_sel),
      .w_k      (w_k),
      .x_k      (x_k),
      .e_val    (e_q),
      .acc_in   (acc_q),
      .acc_out  (acc_next),
      .w_new    (w_new)
   );

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      w_d         = w_q;
      d_d         = d_q;
      adapt_d     = adapt_q;
      acc_d       = acc_q;
      k_d         = k_q;
      y_d         = y_q;
      e_d         = e_q;
      out_valid_d = 1'b0;
      overrun_d   = overrun_q;

      y_calc = DW'(sat_dw(SAT_W'(acc_q) >>> (DW - 1), DW));
      // One guard bit keeps d - y exact before clamping.
      e_wide = {d_q[DW-1], d_q} - {y_calc[DW-1], y_calc};

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               x_d[0] = bus.x_in;
               for (int j = 1; j < TAPS; j++) begin
                  x_d[j] = x_q[j-1];
               end
               d_d     = bus.d_in;
               adapt_d = bus.adapt_en;
               acc_d   = '0;
               k_d     = '0;
               state_d = FILTER;
            end
         end
         FILTER: begin
            acc_d = acc_next;
            if (k_q == K_LAST) begin
               k_d     = '0;
               state_d = ERROR;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         ERROR: begin
            y_d         = y_calc;
            e_d         = DW'(sat_dw(SAT_W'(e_wide), DW));
            out_valid_d = 1'b1;
            k_d         = '0;
            state_d     = adapt_q ? UPDATE : IDLE;
         end
         UPDATE: begin
            w_d[k_q] = w_new;
            if (k_q == K_LAST) begin
               k_d     = '0;
               state_d = IDLE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // A sample arriving mid-computation is dropped but remembered.
      if (bus.in_valid && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         for (int j = 0; j < TAPS; j++) begin
            x_q[j] <= '0;
            w_q[j] <= '0;
         end
         d_q         <= '0;
         adapt_q     <= 1'b0;
         acc_q       <= '0;
         k_q         <= '0;
         y_q         <= '0;
         e_q         <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         w_q         <= w_d;
         d_q         <= d_d;
         adapt_q     <= adapt_d;
         acc_q       <= acc_d;
         k_q         <= k_d;
         y_q         <= y_d;
         e_q         <= e_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.y_out     = y_q;
   assign bus.e_out     = e_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.overrun   = overrun_q;
endmodule

// File: doc/lms_filter.md
# lms_filter

Adaptive LMS FIR filter stage that consumes the 24-bit signed sine samples produced by the on-chip sine generator (reference input `x_in`) together with a desired signal `d_in`. It produces the filter output `y_out` and the error `e_out`. Between input samples the stage has thousands of idle clocks, so one multiplier is time-shared:
- TAPS multiply-accumulate cycles compute the output.
- TAPS further cycles update the coefficients.

It sits directly downstream of the generator on the FPGA datapath.

## Interface
- `DW`, 24: sample, coefficient and error width, signed Q1.23.
- `TAPS`, 8: number of filter taps, ≥2.
- `MU_SHIFT`, 8: step size µ = 2^-MU_SHIFT, applied as an arithmetic right shift.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `x_in`  in  DW  reference sample, signed.
- `d_in`  in  DW  desired sample, signed.
- `in_valid`  in  1  one-cycle strobe; `x_in`, `d_in` and `adapt_en` are sampled in the same cycle.
- `adapt_en`  in  1  when 1, coefficients are updated for this sample.
- `y_out`  out  DW  filter output, registered.
- `e_out`  out  DW  error `d − y`, registered.
- `out_valid`  out  1  one-cycle pulse when `y_out` and `e_out` change.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `overrun`  out  1  sticky; set when `in_valid` arrives while busy.

## Operation
- **State:** delay line `x[0..TAPS-1]`, coefficients `w[0..TAPS-1]`, latched `d`, latched `adapt_en`, accumulator `acc` of width 2·DW+clog2(TAPS), tap index `k`.
- **FSM:** IDLE → FILTER → ERROR → UPDATE → IDLE. When the latched `adapt_en` = 0, ERROR goes straight to IDLE.
- **IDLE:** on `in_valid`:
  - shift the delay line (`x[0] ← x_in`, `x[j] ← x[j-1]`, oldest sample dropped);
  - latch `d_in` and `adapt_en`;
  - clear `acc`, set `k = 0`, go to FILTER.
- **FILTER:** one tap per cycle, `acc += w[k]·x[k]`. Leave after k = TAPS−1.
- **ERROR (one cycle):**
  - `y = sat_DW(acc >>> (DW−1))`;
  - `e = sat_DW(d − y)`, computed in DW+1 bits;
  - register both into `y_out`/`e_out` and pulse `out_valid`.
- **UPDATE:** one tap per cycle, `w[k] = sat_DW(w[k] + ((e·x[k]) >>> (DW−1+MU_SHIFT)))`. The delay line is unchanged during UPDATE.
- **Arithmetic rules:** all shifts are arithmetic with truncation toward −∞. Saturation clamps to +0x7FFFFF / −0x800000 and never wraps.
- **Overrun:** `in_valid` while busy is ignored (no state change) and sets `overrun` until reset.
- **Reset:** reset dominates every state, including mid-FILTER or mid-UPDATE. It aborts to IDLE and zeroes the delay line, `w`, `acc`, `y_out`, `e_out`, `out_valid`, `busy` and `overrun`.

## Timing
- `in_valid` sampled high in cycle c (edge ending c):
  - FILTER in cycles c+1 … c+TAPS;
  - ERROR in cycle c+TAPS+1;
  - `out_valid` = 1 and new `y_out`/`e_out` visible in cycle c+TAPS+2.
- **Adapting (`adapt_en` = 1):** UPDATE in cycles c+TAPS+2 … c+2·TAPS+1; back in IDLE in c+2·TAPS+2.
- **Not adapting (`adapt_en` = 0):** back in IDLE in c+TAPS+2.
- **`busy`:** high in cycles c+1 through the last non-IDLE cycle.
- **Earliest next accepted `in_valid`:** c+2·TAPS+2 when adapting, c+TAPS+2 when not. An `in_valid` in the very cycle IDLE is re-entered is accepted.
- **Outputs after reset:** all 0 in the first cycle after reset deasserts.

## Structure
- Package `lms_pkg` holds:
  - the state enum (IDLE, FILTER, ERROR, UPDATE);
  - localparams for saturation limits and the accumulator width;
  - a `sat_dw` narrowing function.
- One natural sub-module is `lms_mac`: a shared signed DW×DW multiplier feeding an add/saturate path, muxed between FILTER and UPDATE. Everything else stays in `lms_filter`.

## Test plan
All scenarios use the defaults unless stated.
- **Reset:** assert `reset` for 3 cycles mid-UPDATE → next cycle all outputs 0, `busy` = 0; a following sample with `x_in` = 0x100000 gives `y_out` = 0.
- **Zero coefficients:** `x_in` = 0x100000, `d_in` = 0x200000 at cycle c →
  - `y_out` = 0, `e_out` = 0x200000, `out_valid` only in c+10;
  - `busy` high in c+1 … c+17.
- **Single adaptation:**
  - sample 1: `x_in` = 0x400000, `d_in` = 0x400000, `adapt_en` = 1 → `e_out` = 0x400000, and `w[0]` becomes 0x002000;
  - sample 2: `x_in` = 0x400000, `d_in` = 0 → `y_out` = 0x001000, `e_out` = 0xFFF000.
- **Freeze:** repeat the previous two samples with `adapt_en` = 0 → both `y_out` = 0, `busy` lasts 9 cycles.
- **Overrun:** `in_valid` at c and c+3 → exactly one `out_valid`, `overrun` = 1 from c+4 until reset.
- **Saturation (`MU_SHIFT` = 0):**
  - sample 1: `x_in` = `d_in` = 0x7FFFFF → `w[0]` becomes 0x7FFFFE;
  - sample 2: `x_in` = 0x800000, `d_in` = 0x7FFFFF → `y_out` = 0x800002, `e_out` = 0x7FFFFF (saturated, no wrap).
